// File: rtl/color_target_sched.sv
// Colour-target scheduler: rotates four colour slots through a shared
// detector once per frame, latches the detector's bounding box for the
// slot that was active, and calibrates a slot's colour by averaging a
// 4x4 pixel window over one frame.
//
// Calibration FSM
//   state   | meaning
//   IDLE    | waiting for iCalReq; slot number captured on request
//   ARM     | waiting for the next frame end to start a clean frame
//   ACCUM   | summing window pixels of the current frame
//   WRITE   | storing the 16-pixel average into the captured slot
module color_target_sched #(
    parameter logic [21:0] THRESH = 22'd40000,
    parameter logic [10:0] CAL_X0 = 11'd318,
    parameter logic [10:0] CAL_Y0 = 11'd238
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    input  logic [3:0]  iSlotEn,
    input  logic        iCalReq,
    input  logic [1:0]  iCalSlot,
    input  logic [10:0] iXLeft,
    input  logic [10:0] iXRight,
    input  logic [10:0] iYTop,
    input  logic [10:0] iYBot,
    output logic [9:0]  targetRed,
    output logic [9:0]  targetGreen,
    output logic [9:0]  targetBlue,
    output logic [21:0] oColorTarget,
    output logic [1:0]  oSlot,
    output logic        oDetEn,
    output logic        oBoxValid,
    output logic [1:0]  oBoxSlot,
    output logic [10:0] oXLeft,
    output logic [10:0] oXRight,
    output logic [10:0] oYTop,
    output logic [10:0] oYBot,
    output logic        oCalBusy,
    output logic        oCalDone
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_ACCUM = 2'd2,
        S_WRITE = 2'd3
    } cal_state_t;

    localparam logic [10:0] CAL_X1 = CAL_X0 + 11'd3;
    localparam logic [10:0] CAL_Y1 = CAL_Y0 + 11'd3;

    cal_state_t  r_state;
    cal_state_t  w_state_next;
    logic        w_cap;
    logic        w_clr;
    logic        w_acc_en;
    logic        w_wr;

    logic        w_fe;
    logic        w_in_win;

    logic [9:0]  r_col_r [4];
    logic [9:0]  r_col_g [4];
    logic [9:0]  r_col_b [4];
    logic [13:0] r_acc_r;
    logic [13:0] r_acc_g;
    logic [13:0] r_acc_b;
    logic [1:0]  r_cal_slot;

    logic [1:0]  r_slot;
    logic        r_det_en;
    logic [1:0]  w_slot_next;
    logic [1:0]  w_cand;
    logic        w_found;

    logic [9:0]  r_tgt_r;
    logic [9:0]  r_tgt_g;
    logic [9:0]  r_tgt_b;
    logic [9:0]  w_tgt_r;
    logic [9:0]  w_tgt_g;
    logic [9:0]  w_tgt_b;

    logic        r_box_valid;
    logic [1:0]  r_box_slot;
    logic [10:0] r_xl;
    logic [10:0] r_xr;
    logic [10:0] r_yt;
    logic [10:0] r_yb;

    assign w_fe     = iDVAL && (iX_Cont == 11'd639) && (iY_Cont == 11'd479);
    assign w_in_win = iDVAL && (iX_Cont >= CAL_X0) && (iX_Cont <= CAL_X1)
                            && (iY_Cont >= CAL_Y0) && (iY_Cont <= CAL_Y1);
    assign w_wr     = (r_state == S_WRITE);

    // Calibration FSM state register
    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Calibration FSM next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_cap        = 1'b0;
        w_clr        = 1'b0;
        w_acc_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iCalReq) begin
                    w_state_next = S_ARM;
                    w_cap        = 1'b1;
                end
            end
            S_ARM: begin
                if (w_fe) begin
                    w_state_next = S_ACCUM;
                    w_clr        = 1'b1;
                end
            end
            S_ACCUM: begin
                w_acc_en = w_in_win;
                if (w_fe) w_state_next = S_WRITE;
            end
            S_WRITE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Captured calibration slot and window accumulators
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cal_slot <= 2'd0;
            r_acc_r    <= 14'd0;
            r_acc_g    <= 14'd0;
            r_acc_b    <= 14'd0;
        end else begin
            if (w_cap) r_cal_slot <= iCalSlot;
            if (w_clr) begin
                r_acc_r <= 14'd0;
                r_acc_g <= 14'd0;
                r_acc_b <= 14'd0;
            end else if (w_acc_en) begin
                r_acc_r <= r_acc_r + {4'd0, iRed};
                r_acc_g <= r_acc_g + {4'd0, iGreen};
                r_acc_b <= r_acc_b + {4'd0, iBlue};
            end
        end
    end

    // Slot colour registers, written only from the WRITE state
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_col_r[0] <= 10'd1023; r_col_g[0] <= 10'd0;    r_col_b[0] <= 10'd0;
            r_col_r[1] <= 10'd0;    r_col_g[1] <= 10'd1023; r_col_b[1] <= 10'd0;
            r_col_r[2] <= 10'd0;    r_col_g[2] <= 10'd0;    r_col_b[2] <= 10'd1023;
            r_col_r[3] <= 10'd1023; r_col_g[3] <= 10'd1023; r_col_b[3] <= 10'd0;
        end else if (w_wr) begin
            r_col_r[r_cal_slot] <= r_acc_r[13:4];
            r_col_g[r_cal_slot] <= r_acc_g[13:4];
            r_col_b[r_cal_slot] <= r_acc_b[13:4];
        end
    end

    // Next slot: first enabled slot searching forward from the current one
    always_comb begin
        w_slot_next = r_slot;
        w_cand      = r_slot;
        w_found     = 1'b0;
        if (w_fe) begin
            for (int k = 1; k <= 4; k++) begin
                w_cand = r_slot + 2'(k);
                if (!w_found && iSlotEn[w_cand]) begin
                    w_slot_next = w_cand;
                    w_found     = 1'b1;
                end
            end
        end
    end

    // Slot pointer and detector enable, updated once per frame end
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_slot   <= 2'd0;
            r_det_en <= 1'b0;
        end else if (w_fe) begin
            r_slot   <= w_slot_next;
            r_det_en <= (iSlotEn != 4'd0);
        end
    end

    // Target colour for the upcoming slot; forwards a colour written this cycle
    always_comb begin
        w_tgt_r = r_col_r[w_slot_next];
        w_tgt_g = r_col_g[w_slot_next];
        w_tgt_b = r_col_b[w_slot_next];
        if (w_wr && (r_cal_slot == w_slot_next)) begin
            w_tgt_r = r_acc_r[13:4];
            w_tgt_g = r_acc_g[13:4];
            w_tgt_b = r_acc_b[13:4];
        end
    end

    // Registered target colour outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_tgt_r <= 10'd1023;
            r_tgt_g <= 10'd0;
            r_tgt_b <= 10'd0;
        end else begin
            r_tgt_r <= w_tgt_r;
            r_tgt_g <= w_tgt_g;
            r_tgt_b <= w_tgt_b;
        end
    end

    // Box latch for the slot whose detector results were valid this frame
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_box_valid <= 1'b0;
            r_box_slot  <= 2'd0;
            r_xl        <= 11'd0;
            r_xr        <= 11'd0;
            r_yt        <= 11'd0;
            r_yb        <= 11'd0;
        end else begin
            r_box_valid <= w_fe && r_det_en;
            if (w_fe && r_det_en) begin
                r_box_slot <= r_slot;
                r_xl       <= iXLeft;
                r_xr       <= iXRight;
                r_yt       <= iYTop;
                r_yb       <= iYBot;
            end
        end
    end

    assign targetRed    = r_tgt_r;
    assign targetGreen  = r_tgt_g;
    assign targetBlue   = r_tgt_b;
    assign oColorTarget = THRESH;
    assign oSlot        = r_slot;
    assign oDetEn       = r_det_en;
    assign oBoxValid    = r_box_valid;
    assign oBoxSlot     = r_box_slot;
    assign oXLeft       = r_xl;
    assign oXRight      = r_xr;
    assign oYTop        = r_yt;
    assign oYBot        = r_yb;
    assign oCalBusy     = (r_state != S_IDLE);
    assign oCalDone     = (r_state == S_WRITE);

endmodule

// File: tb/tb_color_target_sched.sv
// Directed bench for color_target_sched with a box/calibration scoreboard.
module tb_color_target_sched;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iDVAL = 1'b0;
    logic [10:0] iX_Cont = '0, iY_Cont = '0;
    logic [9:0]  iRed = '0, iGreen = '0, iBlue = '0;
    logic [3:0]  iSlotEn = '0;
    logic        iCalReq = 1'b0;
    logic [1:0]  iCalSlot = '0;
    logic [10:0] iXLeft = '0, iXRight = '0, iYTop = '0, iYBot = '0;
    logic [9:0]  targetRed, targetGreen, targetBlue;
    logic [21:0] oColorTarget;
    logic [1:0]  oSlot, oBoxSlot;
    logic        oDetEn, oBoxValid, oCalBusy, oCalDone;
    logic [10:0] oXLeft, oXRight, oYTop, oYBot;

    int n_checks = 0;
    int n_fail   = 0;

    logic [45:0] box_q[$];
    logic [1:0]  cal_q[$];
    logic [1:0]  m_slot = 2'd0;
    logic        m_det  = 1'b0;

    color_target_sched dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iSlotEn(iSlotEn), .iCalReq(iCalReq), .iCalSlot(iCalSlot),
        .iXLeft(iXLeft), .iXRight(iXRight), .iYTop(iYTop), .iYBot(iYBot),
        .targetRed(targetRed), .targetGreen(targetGreen), .targetBlue(targetBlue),
        .oColorTarget(oColorTarget), .oSlot(oSlot), .oDetEn(oDetEn),
        .oBoxValid(oBoxValid), .oBoxSlot(oBoxSlot),
        .oXLeft(oXLeft), .oXRight(oXRight), .oYTop(oYTop), .oYBot(oYBot),
        .oCalBusy(oCalBusy), .oCalDone(oCalDone)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        m_slot = 2'd0;
        m_det  = 1'b0;
    endtask

    task automatic chk_tgt(input string nm, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        chk({nm, "_red"}, 64'(targetRed), 64'(r));
        chk({nm, "_green"}, 64'(targetGreen), 64'(g));
        chk({nm, "_blue"}, 64'(targetBlue), 64'(b));
    endtask

    // One frame-end cycle; expected box and slot progression come from the bench model
    task automatic fe(input logic [3:0] en, input logic [10:0] xl, input logic [10:0] xr,
                      input logic [10:0] yt, input logic [10:0] yb);
        logic found;
        logic [1:0] c;
        iSlotEn = en; iDVAL = 1'b1; iX_Cont = 11'd639; iY_Cont = 11'd479;
        iXLeft = xl; iXRight = xr; iYTop = yt; iYBot = yb;
        if (m_det) box_q.push_back({m_slot, xl, xr, yt, yb});
        if (en != 4'd0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = 2'((int'(m_slot) + k) % 4);
                if (!found && en[c]) begin
                    m_slot = c;
                    found  = 1'b1;
                end
            end
            m_det = 1'b1;
        end else begin
            m_det = 1'b0;
        end
        tick();
        iDVAL = 1'b0; iX_Cont = 11'd0; iY_Cont = 11'd0;
        chk("slot_model", 64'(oSlot), 64'(m_slot));
        chk("deten_model", 64'(oDetEn), 64'(m_det));
    endtask

    task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic [9:0] r,
                       input logic [9:0] g, input logic [9:0] b, input logic dv);
        iX_Cont = x; iY_Cont = y; iRed = r; iGreen = g; iBlue = b; iDVAL = dv;
        tick();
        iDVAL = 1'b0;
    endtask

    task automatic cal_req(input logic [1:0] s);
        iCalReq = 1'b1; iCalSlot = s;
        tick();
        iCalReq = 1'b0;
    endtask

    // Monitor: every box strobe or calibration-done strobe must match a queued expectation
    always @(negedge iCLK) begin
        if (oBoxValid) begin
            if (box_q.size() == 0) begin
                chk("box_unexpected", 64'(oBoxValid), 64'd0);
            end else begin
                chk("box_scoreboard", {18'd0, oBoxSlot, oXLeft, oXRight, oYTop, oYBot},
                    64'(box_q.pop_front()));
            end
        end
        if (oCalDone) begin
            chk("caldone_expected", 64'(cal_q.size() != 0), 64'd1);
            if (cal_q.size() != 0) void'(cal_q.pop_front());
        end
    end

    initial begin
        iRST = 1'b1;
        tick();
        do_reset();
        chk("rst_slot", 64'(oSlot), 64'd0);
        chk("rst_deten", 64'(oDetEn), 64'd0);
        chk_tgt("rst_tgt", 10'd1023, 10'd0, 10'd0);
        chk("thresh", 64'(oColorTarget), 64'd40000);
        chk("rst_boxvalid", 64'(oBoxValid), 64'd0);
        chk("rst_box", {20'd0, oBoxSlot, oXLeft, oXRight, oYTop, oYBot}, 64'd0);
        chk("rst_busy", 64'(oCalBusy), 64'd0);
        chk("rst_done", 64'(oCalDone), 64'd0);

        // Slot rotation with mask 0101
        fe(4'b0101, 11'd1, 11'd2, 11'd3, 11'd4);
        chk("fe1_slot", 64'(oSlot), 64'd2);
        chk("fe1_deten", 64'(oDetEn), 64'd1);
        chk("fe1_nobox", 64'(oBoxValid), 64'd0);
        chk_tgt("fe1_tgt", 10'd0, 10'd0, 10'd1023);
        fe(4'b0101, 11'd10, 11'd200, 11'd20, 11'd300);
        chk("fe2_slot", 64'(oSlot), 64'd0);
        chk("fe2_boxvalid", 64'(oBoxValid), 64'd1);
        chk("fe2_boxslot", 64'(oBoxSlot), 64'd2);
        chk("fe2_xl", 64'(oXLeft), 64'd10);
        chk("fe2_xr", 64'(oXRight), 64'd200);
        chk("fe2_yt", 64'(oYTop), 64'd20);
        chk("fe2_yb", 64'(oYBot), 64'd300);
        tick();
        chk("fe2_pulse_one_cycle", 64'(oBoxValid), 64'd0);
        fe(4'b0101, 11'd5, 11'd6, 11'd7, 11'd8);
        chk("fe3_slot", 64'(oSlot), 64'd2);
        chk("fe3_boxslot", 64'(oBoxSlot), 64'd0);

        // Empty mask: detector off, slot held, box outputs held
        fe(4'b0000, 11'd30, 11'd31, 11'd32, 11'd33);
        chk("fe4_deten", 64'(oDetEn), 64'd0);
        chk("fe4_slot", 64'(oSlot), 64'd2);
        fe(4'b0000, 11'd99, 11'd98, 11'd97, 11'd96);
        chk("fe5_nobox", 64'(oBoxValid), 64'd0);
        chk("fe5_hold_xl", 64'(oXLeft), 64'd30);
        fe(4'b0010, 11'd0, 11'd0, 11'd0, 11'd0);
        chk("fe6_slot", 64'(oSlot), 64'd1);
        chk_tgt("fe6_tgt", 10'd0, 10'd1023, 10'd0);

        // Calibrate slot 1 to (400,800,100); a second request while busy is ignored
        cal_req(2'd1);
        chk("cal1_busy", 64'(oCalBusy), 64'd1);
        cal_req(2'd3);
        fe(4'b0010, 11'd1, 11'd2, 11'd3, 11'd4);
        chk("cal1_busy_accum", 64'(oCalBusy), 64'd1);
        for (int y = 238; y <= 241; y++)
            for (int x = 318; x <= 321; x++)
                pix(11'(x), 11'(y), 10'd400, 10'd800, 10'd100, 1'b1);
        pix(11'd317, 11'd238, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        pix(11'd322, 11'd240, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        pix(11'd319, 11'd237, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        pix(11'd319, 11'd242, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        pix(11'd320, 11'd239, 10'd1023, 10'd1023, 10'd1023, 1'b0);
        cal_q.push_back(2'd1);
        fe(4'b0010, 11'd11, 11'd12, 11'd13, 11'd14);
        chk("cal1_done", 64'(oCalDone), 64'd1);
        tick();
        chk("cal1_done_pulse", 64'(oCalDone), 64'd0);
        chk("cal1_busy_clear", 64'(oCalBusy), 64'd0);
        fe(4'b0010, 11'd15, 11'd16, 11'd17, 11'd18);
        chk_tgt("cal1_tgt", 10'd400, 10'd800, 10'd100);

        // Calibrate slot 3 with alternating 0/1023 window pixels -> 511
        cal_req(2'd3);
        fe(4'b0010, 11'd21, 11'd22, 11'd23, 11'd24);
        for (int i = 0; i < 16; i++)
            pix(11'(318 + (i % 4)), 11'(238 + (i / 4)),
                (i % 2 == 1) ? 10'd1023 : 10'd0,
                (i % 2 == 1) ? 10'd1023 : 10'd0,
                (i % 2 == 1) ? 10'd1023 : 10'd0, 1'b1);
        pix(11'd100, 11'd100, 10'd1023, 10'd1023, 10'd1023, 1'b1);
        cal_q.push_back(2'd3);
        fe(4'b0010, 11'd25, 11'd26, 11'd27, 11'd28);
        chk("cal3_done", 64'(oCalDone), 64'd1);
        tick();
        fe(4'b1000, 11'd31, 11'd32, 11'd33, 11'd34);
        chk("cal3_slot", 64'(oSlot), 64'd3);
        chk_tgt("cal3_tgt", 10'd511, 10'd511, 10'd511);

        // Reset in the middle of accumulation aborts without a write
        cal_req(2'd0);
        fe(4'b1000, 11'd41, 11'd42, 11'd43, 11'd44);
        for (int i = 0; i < 4; i++)
            pix(11'(318 + i), 11'd238, 10'd500, 10'd500, 10'd500, 1'b1);
        tick();
        do_reset();
        chk("abort_busy", 64'(oCalBusy), 64'd0);
        chk("abort_done", 64'(oCalDone), 64'd0);
        chk("abort_slot", 64'(oSlot), 64'd0);
        chk("abort_box", {20'd0, oBoxSlot, oXLeft, oXRight, oYTop, oYBot}, 64'd0);
        chk_tgt("abort_tgt0", 10'd1023, 10'd0, 10'd0);
        for (int i = 0; i < 20; i++) tick();
        fe(4'b0010, 11'd0, 11'd0, 11'd0, 11'd0);
        chk_tgt("abort_tgt1", 10'd0, 10'd1023, 10'd0);
        fe(4'b1000, 11'd51, 11'd52, 11'd53, 11'd54);
        chk_tgt("abort_tgt3", 10'd1023, 10'd1023, 10'd0);
        fe(4'b0001, 11'd61, 11'd62, 11'd63, 11'd64);
        chk_tgt("abort_tgt0b", 10'd1023, 10'd0, 10'd0);

        for (int i = 0; i < 5; i++) tick();
        chk("box_queue_drained", 64'(box_q.size()), 64'd0);
        chk("cal_queue_drained", 64'(cal_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
